// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared types and constants for the sequential divider
package booth_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int DIV_W = 32;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division step (shift, trial subtract, select)
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic             msb,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   pr_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] diff;
  // Two extra bits keep the trial sign visible for any shifted remainder
  assign diff    = {pr, msb} - {2'b00, dsr};
  assign q_bit   = ~diff[WIDTH+1];
  assign pr_next = q_bit ? diff[WIDTH:0] : {pr[WIDTH-1:0], msb};
endmodule

// File: rtl/booth_seq_divider.sv
// booth_seq_divider: iterative signed restoring divider, one quotient bit per cycle
module booth_seq_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_Valid,
  output logic             Div_By_Zero,
  output logic             Busy
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] pr, pr_nx;
  logic [WIDTH-1:0] dvd, dsr, a_raw;
  logic sign_q, sign_r, zero, q_bit;
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .pr(pr), .msb(dvd[WIDTH-1]), .dsr(dsr), .pr_next(pr_nx), .q_bit(q_bit)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dvd         <= '0;
      dsr         <= '0;
      a_raw       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      Div_Valid   <= 1'b0;
      Div_By_Zero <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Div_Valid <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          sign_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
          sign_r <= in_a[WIDTH-1];
          dvd    <= in_a[WIDTH-1] ? -in_a : in_a;
          dsr    <= in_b[WIDTH-1] ? -in_b : in_b;
          a_raw  <= in_a;
          zero   <= in_b == '0;
          pr     <= '0;
          cnt    <= '0;
          Busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          pr    <= pr_nx;
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          state <= cnt == CNT_W'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          Quotient    <= zero ? WIDTH'(DBZ_QUOTIENT) : sign_q ? -dvd : dvd;
          Remainder   <= zero ? a_raw : sign_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
          Div_By_Zero <= zero;
          Div_Valid   <= 1'b1;
          Busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
Iterative signed 32/32 restoring divider. It is the inverse companion of the team's sequential Booth multiplier and shares its CLK/RST domain and its operand conventions (in_a, in_b).
- Produces quotient and remainder, one quotient bit per cycle.
- Uses a Start/Busy/Valid handshake.
- Feeds the ALU datapath, which checks results by multiply-back.

Parameters:
WIDTH, 32, operand/result width in bits (verified only at 32)
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
Start  input  1  request; sampled only while Busy=0
in_a  input  WIDTH  dividend, two's complement
in_b  input  WIDTH  divisor, two's complement
Quotient  output  WIDTH  signed quotient, registered
Remainder  output  WIDTH  signed remainder, registered
Div_Valid  output  1  one-cycle pulse: Quotient/Remainder updated
Div_By_Zero  output  1  registered with result; 1 when divisor was 0
Busy  output  1  high from the edge accepting Start until the edge asserting Div_Valid

Behaviour:
Reset (RST=1, at any time, including mid-operation):
- State goes to IDLE and the counter is cleared.
- Quotient=0, Remainder=0, Div_Valid=0, Div_By_Zero=0, Busy=0.
- An operation in flight is abandoned and produces no Div_Valid.

FSM states: IDLE, CALC, FIX.
- IDLE: on an edge with Start=1:
  - latch sign_q = in_a[MSB]^in_b[MSB] and sign_r = in_a[MSB];
  - latch |in_a| and |in_b| as unsigned WIDTH-bit magnitudes (|0x80000000| = 0x80000000);
  - latch zero flag = (in_b==0);
  - clear the partial remainder (WIDTH+1 bits) and the counter; Busy<=1; go to CALC.
- CALC: exactly WIDTH edges, one restoring step per edge:
  - shift {PR, dividend_mag} left by 1;
  - trial = PR - divisor_mag;
  - if trial >= 0: PR <= trial and the new LSB of dividend_mag becomes 1; else keep PR and the LSB becomes 0.
  - The counter increments; after step WIDTH, go to FIX.
- FIX: one edge.
  - Quotient <= sign_q ? -qmag : qmag (mod 2^WIDTH).
  - Remainder <= sign_r ? -PR : PR.
  - Div_Valid<=1 for this cycle only, Busy<=0, go to IDLE.

Latency and handshake:
- Start accepted at edge t0; Div_Valid is high after edge t0+WIDTH+1 (t0+33), for 1 cycle.
- Latency is constant for all operand values, including divide-by-zero.
- Start while Busy=1 is ignored; the in-flight operands are unaffected.
- Start in the same cycle as Div_Valid is ignored, because Busy is still 1 on that edge. Earliest next accept is the following edge.
- Outputs hold their last value between results.

Arithmetic rules:
- Quotient truncates toward zero; the remainder takes the sign of the dividend; |Remainder| < |divisor|.
- Divisor 0: Quotient=all ones, Remainder=in_a unchanged, Div_By_Zero=1. Applied in FIX, overriding the sign fix-up.
- 0x80000000 / -1: Quotient=0x80000000 (wraps), Remainder=0, Div_By_Zero=0. No separate overflow flag.
- Div_By_Zero is updated only together with Div_Valid.

Decomposition:
- Package booth_div_pkg contains:
  - state enum {IDLE, CALC, FIX};
  - DIV_W=32;
  - constant DBZ_QUOTIENT = all ones.
- One natural sub-module, div_restore_step: combinational shift/trial-subtract/select for one bit. Inputs are PR, dividend MSB and divisor_mag; outputs are next PR and the quotient bit. It is instantiated once inside CALC.
- The sign fix-up and FSM stay in the top module.

Test Plan:
- Accept and latency: Start with 100 / 7 -> Busy high for 33 cycles; Div_Valid pulse exactly at t0+33; Quotient=14, Remainder=2, Div_By_Zero=0.
- Sign rules: -100/7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2). 100/-7 -> Q=-14, R=2. -100/-7 -> Q=14, R=-2.
- Divide by zero: 7/0 -> Q=0xFFFFFFFF, R=7, Div_By_Zero=1, same 33-cycle latency. The next op, 9/3, returns Q=3, R=0, Div_By_Zero=0.
- Extremes: 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0. 0x7FFFFFFF/1 -> Q=0x7FFFFFFF, R=0. 0/5 -> Q=0, R=0.
- Start while busy: Start 50/5, then Start 99/9 at cycle 10 -> only one Div_Valid, with Q=10, R=0. Start held continuously -> back-to-back results, Valid pulses 34 cycles apart.
- Reset mid-operation: assert RST at cycle 12 of 1000/3 -> all outputs immediately 0, no Div_Valid. The next Start 1000/3 -> Q=333, R=1.
